// File: rtl/lfsr_gen.sv
// lfsr_gen: width-parameterised tap-programmable LFSR with Fibonacci or
// Galois feedback, single-step advance, a multi-cycle skip-ahead engine with
// busy/done handshake, an advance counter and a lock-up status flag.
//
// Command priority per edge: init > set > skip_start > Advance. While a skip
// is running the engine owns the advance path; skip_start and Advance are
// ignored, and only init or set can abort it (without a done pulse).

module lfsr_gen #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GALOIS = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             init,
  input  logic             set,
  input  logic             Advance,
  input  logic             skip_start,
  input  logic [CNT_W-1:0] skip_cnt,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] state,
  output logic             fb_bit,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] taptrn_q, taptrn_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] next_val;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             done_q, done_d;
  logic             do_adv;
  logic             fb;

  // Feedback parity of the current state under the loaded tap pattern.
  always_comb begin
    fb = ^(state_q & taptrn_q);
  end

  // Successor state, feedback form fixed at build time.
  generate
    if (GALOIS != 0) begin : g_galois
      always_comb begin
        next_val = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? taptrn_q : '0);
      end
    end else begin : g_fibonacci
      always_comb begin
        next_val = {state_q[WIDTH-2:0], fb};
      end
    end
  endgenerate

  // Command decode, skip FSM next-state and the shared advance path.
  always_comb begin
    fsm_d       = fsm_q;
    taptrn_d    = taptrn_q;
    state_d     = state_q;
    remaining_d = remaining_q;
    step_d      = step_q;
    done_d      = 1'b0;
    do_adv      = 1'b0;

    if (init) begin
      taptrn_d    = in;
      fsm_d       = IDLE;
      remaining_d = '0;
    end else if (set) begin
      state_d     = in;
      step_d      = '0;
      fsm_d       = IDLE;
      remaining_d = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (skip_start) begin
            // A zero-length skip completes immediately without entering SKIP.
            if (skip_cnt == '0) begin
              done_d = 1'b1;
            end else begin
              remaining_d = skip_cnt;
              fsm_d       = SKIP;
            end
          end else if (Advance) begin
            do_adv = 1'b1;
          end
        end
        SKIP: begin
          do_adv      = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end

    if (do_adv) begin
      state_d = next_val;
      step_d  = step_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q       <= IDLE;
      taptrn_q    <= '0;
      state_q     <= '0;
      remaining_q <= '0;
      step_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      taptrn_q    <= taptrn_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    state      = state_q;
    fb_bit     = fb;
    busy       = (fsm_q == SKIP);
    done       = done_q;
    lockup     = (state_q == '0);
    step_count = step_q;
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed plan followed by randomized commands, checking a
// Fibonacci and a Galois instance against an arithmetic reference model.

module tb_lfsr_gen;

  logic       Clk;
  logic       Reset_n;
  logic       init, set, Advance, skip_start;
  logic [7:0] skip_cnt;
  logic [6:0] in;

  logic [6:0] f_state, g_state;
  logic       f_fb, g_fb, f_busy, g_busy, f_done, g_done, f_lock, g_lock;
  logic [7:0] f_cnt, g_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model
  logic [6:0] m_tap, m_fib, m_gal;
  logic [7:0] m_cnt;
  int         m_rem;
  bit         m_busy, m_done;

  lfsr_gen #(.WIDTH(7), .CNT_W(8), .GALOIS(0)) u_fib (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .set(set), .Advance(Advance),
    .skip_start(skip_start), .skip_cnt(skip_cnt), .in(in),
    .state(f_state), .fb_bit(f_fb), .busy(f_busy), .done(f_done),
    .lockup(f_lock), .step_count(f_cnt)
  );

  lfsr_gen #(.WIDTH(7), .CNT_W(8), .GALOIS(1)) u_gal (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .set(set), .Advance(Advance),
    .skip_start(skip_start), .skip_cnt(skip_cnt), .in(in),
    .state(g_state), .fb_bit(g_fb), .busy(g_busy), .done(g_done),
    .lockup(g_lock), .step_count(g_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic int unsigned parity(input logic [6:0] v);
    return $countones(v) % 2;
  endfunction

  function automatic logic [6:0] fib_next(input logic [6:0] s, input logic [6:0] t);
    int unsigned v;
    v = (int'(s) * 2) % 128 + parity(s & t);
    return v[6:0];
  endfunction

  function automatic logic [6:0] gal_next(input logic [6:0] s, input logic [6:0] t);
    int unsigned v;
    v = (int'(s) * 2) % 128;
    if (int'(s) >= 64) v = v ^ int'(t);
    return v[6:0];
  endfunction

  task automatic model_reset();
    m_tap = '0; m_fib = '0; m_gal = '0; m_cnt = '0;
    m_rem = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_adv();
    m_fib = fib_next(m_fib, m_tap);
    m_gal = gal_next(m_gal, m_tap);
    m_cnt = m_cnt + 8'd1;
  endtask

  // One clock edge of the command protocol.
  task automatic model_edge();
    bit nd;
    nd = 0;
    if (init) begin
      m_tap = in; m_busy = 0;
    end else if (set) begin
      m_fib = in; m_gal = in; m_cnt = '0; m_busy = 0;
    end else if (m_busy) begin
      model_adv();
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_busy = 0; nd = 1; end
    end else if (skip_start) begin
      if (skip_cnt == 0) nd = 1;
      else begin m_rem = int'(skip_cnt); m_busy = 1; end
    end else if (Advance) begin
      model_adv();
    end
    m_done = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fib_state", 32'(f_state), 32'(m_fib));
    chk("gal_state", 32'(g_state), 32'(m_gal));
    chk("fib_fb", 32'(f_fb), parity(m_fib & m_tap));
    chk("gal_fb", 32'(g_fb), parity(m_gal & m_tap));
    chk("fib_busy", 32'(f_busy), 32'(m_busy));
    chk("gal_busy", 32'(g_busy), 32'(m_busy));
    chk("fib_done", 32'(f_done), 32'(m_done));
    chk("gal_done", 32'(g_done), 32'(m_done));
    chk("fib_cnt", 32'(f_cnt), 32'(m_cnt));
    chk("gal_cnt", 32'(g_cnt), 32'(m_cnt));
    chk("fib_lock", 32'(f_lock), 32'(m_fib == 0));
    chk("gal_lock", 32'(g_lock), 32'(m_gal == 0));
  endtask

  task automatic step(input bit i, input bit s, input bit a, input bit ss,
                      input int unsigned n, input int unsigned d);
    init = i; set = s; Advance = a; skip_start = ss;
    skip_cnt = n[7:0]; in = d[6:0];
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
    init = 0; set = 0; Advance = 0; skip_start = 0;
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 0, 0);
  endtask

  logic [6:0] exp1 [6];

  initial begin
    exp1 = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
    Reset_n = 1'b0;
    init = 0; set = 0; Advance = 0; skip_start = 0; skip_cnt = '0; in = '0;
    #2;
    model_reset();
    check_all();
    chk("rst_lockup", 32'(f_lock), 32'd1);
    #10 Reset_n = 1'b1;
    tick();

    // 1. Fibonacci single-step
    step(1, 0, 0, 0, 0, 'h60);
    step(0, 1, 0, 0, 0, 'h01);
    chk("t1_seed", 32'(f_state), 32'h01);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 0, 0, 0);
      chk("t1_seq", 32'(f_state), 32'(exp1[k]));
    end
    chk("t1_cnt", 32'(f_cnt), 32'd6);

    // 2. Skip 6, then skip 127 for a full period
    step(0, 1, 0, 0, 0, 'h01);
    step(0, 0, 0, 1, 6, 0);
    chk("t2_busy_start", 32'(f_busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("t2_busy", 32'(f_busy), 32'd1);
      tick();
    end
    chk("t2_done", 32'(f_done), 32'd1);
    chk("t2_state", 32'(f_state), 32'h41);
    chk("t2_cnt", 32'(f_cnt), 32'd6);
    tick();
    chk("t2_done_drop", 32'(f_done), 32'd0);
    step(0, 1, 0, 0, 0, 'h01);
    step(0, 0, 0, 1, 127, 0);
    for (int k = 0; k < 127; k++) tick();
    chk("t2_period", 32'(f_state), 32'h01);
    chk("t2_period_done", 32'(f_done), 32'd1);

    // 3. Abort on 5th busy cycle, then zero-count skip
    step(0, 0, 0, 1, 100, 0);
    for (int k = 0; k < 4; k++) tick();
    step(0, 1, 0, 0, 0, 'h11);
    chk("t3_state", 32'(f_state), 32'h11);
    chk("t3_busy", 32'(f_busy), 32'd0);
    chk("t3_cnt", 32'(f_cnt), 32'd0);
    tick();
    chk("t3_nodone", 32'(f_done), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_zero_done", 32'(f_done), 32'd1);
    chk("t3_zero_busy", 32'(f_busy), 32'd0);
    chk("t3_zero_state", 32'(f_state), 32'h11);
    tick();
    chk("t3_zero_drop", 32'(f_done), 32'd0);

    // 4. Galois
    step(1, 0, 0, 0, 0, 'h03);
    step(0, 1, 0, 0, 0, 'h40);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_gal_a", 32'(g_state), 32'h03);
    step(0, 1, 0, 0, 0, 'h01);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_gal_b", 32'(g_state), 32'h02);

    // 5. Lock-up, then async reset mid-skip
    step(0, 1, 0, 0, 0, 'h00);
    chk("t5_lock", 32'(f_lock), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0);
    chk("t5_lock_state", 32'(f_state), 32'h00);
    chk("t5_lock_cnt", 32'(f_cnt), 32'd3);
    step(1, 0, 0, 0, 0, 'h60);
    step(0, 1, 0, 0, 0, 'h01);
    step(0, 0, 0, 1, 50, 0);
    for (int k = 0; k < 3; k++) tick();
    #3 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t5_rst_state", 32'(f_state), 32'h00);
    chk("t5_rst_busy", 32'(f_busy), 32'd0);
    #2 Reset_n = 1'b1;
    tick();

    // 6. Priority and Advance held during skip
    step(1, 0, 0, 0, 0, 'h60);
    step(0, 1, 0, 0, 0, 'h01);
    step(1, 1, 1, 0, 0, 'h55);
    chk("t6_state", 32'(f_state), 32'h01);
    chk("t6_cnt", 32'(f_cnt), 32'd0);
    chk("t6_fb", 32'(f_fb), 32'd1);
    step(0, 0, 1, 1, 5, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0);
    chk("t6_skip_cnt", 32'(f_cnt), 32'd5);
    chk("t6_skip_done", 32'(f_done), 32'd1);

    // Randomized command mix
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 15,
           $urandom_range(0, 12), $urandom_range(0, 127));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
